// File: rtl/rgb565_gray_sequencer_pkg.sv
// Shared types and constants for the RGB565 grayscale custom instruction.
package rgb565_gray_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_e;

    // Default channel weights (sum to 256, so white maps to just under 8'hFF).
    localparam logic [7:0] DefWr = 8'd54;
    localparam logic [7:0] DefWg = 8'd183;
    localparam logic [7:0] DefWb = 8'd19;

    // The config instruction lives at the convert ID plus this offset.
    localparam logic [7:0] CfgIdOffset = 8'd1;

    localparam logic [7:0] GraySat = 8'hFF;

endpackage

// File: rtl/rgb565_gray_sequencer_pixel.sv
// Combinational weighted-sum grayscale for one RGB565 pixel, saturated to 8 bits.
module rgb565_gray_sequencer_pixel
    import rgb565_gray_sequencer_pkg::*;
(
    input  logic [15:0] pixel_i,
    input  logic [7:0]  wr_i,
    input  logic [7:0]  wg_i,
    input  logic [7:0]  wb_i,
    output logic [7:0]  gray_o
);

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [17:0] sum;

    // Expand channels to 8 bits, weight them and saturate the scaled sum.
    always_comb begin
        r8     = {pixel_i[15:11], 3'b000};
        g8     = {pixel_i[10:5], 2'b00};
        b8     = {pixel_i[4:0], 3'b000};
        sum    = 18'(r8) * 18'(wr_i) + 18'(g8) * 18'(wg_i) + 18'(b8) * 18'(wb_i);
        gray_o = (sum[17:16] != 2'b00) ? GraySat : sum[15:8];
    end

endmodule

// File: rtl/rgb565_gray_sequencer.sv
// Custom-instruction sequencer: converts four RGB565 pixels to gray, one per cycle,
// and holds programmable channel weights loaded by a second instruction ID.
module rgb565_gray_sequencer
    import rgb565_gray_sequencer_pkg::*;
#(
    parameter logic [7:0] customInstructionID = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  isId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [7:0] CfgId = customInstructionID + CfgIdOffset;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] operand_q, operand_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  wr_q, wr_d;
    logic [7:0]  wg_q, wg_d;
    logic [7:0]  wb_q, wb_d;

    logic        conv_hit;
    logic        cfg_hit;
    logic [15:0] cur_pixel;
    logic [7:0]  cur_gray;

    // Instructions are only honoured in IDLE; anything else is a protocol error.
    assign conv_hit  = start && (isId == customInstructionID) && (state_q == StIdle);
    assign cfg_hit   = start && (isId == CfgId) && (state_q == StIdle);
    assign cur_pixel = operand_q[{idx_q, 4'b0000} +: 16];

    rgb565_gray_sequencer_pixel u_pixel (
        .pixel_i (cur_pixel),
        .wr_i    (wr_q),
        .wg_i    (wg_q),
        .wb_i    (wb_q),
        .gray_o  (cur_gray)
    );

    // Next-state logic for the FSM, operand/result registers and weights.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        operand_d = operand_q;
        result_d  = result_q;
        wr_d      = wr_q;
        wg_d      = wg_q;
        wb_d      = wb_q;
        unique case (state_q)
            StIdle: begin
                if (conv_hit) begin
                    operand_d = {valueB, valueA};
                    idx_d     = 2'd0;
                    state_d   = StConv;
                end else if (cfg_hit) begin
                    wr_d = valueA[7:0];
                    wg_d = valueA[15:8];
                    wb_d = valueA[23:16];
                end
            end
            StConv: begin
                result_d[{idx_q, 3'b000} +: 8] = cur_gray;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any operation and restores default weights.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            operand_q <= 64'd0;
            result_q  <= 32'd0;
            wr_q      <= DefWr;
            wg_q      <= DefWg;
            wb_q      <= DefWb;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            wr_q      <= wr_d;
            wg_q      <= wg_d;
            wb_q      <= wb_d;
        end
    end

    // Convert completion is decoded from DONE; config completes combinationally.
    always_comb begin
        done   = 1'b0;
        result = 32'd0;
        if (state_q == StDone) begin
            done   = 1'b1;
            result = result_q;
        end else if (cfg_hit) begin
            done   = 1'b1;
            result = {8'd0, wb_q, wg_q, wr_q};
        end
    end

endmodule

// File: tb/tb_rgb565_gray_sequencer.sv
// Self-checking bench: fixed vectors, hand-written corner sequences and random converts.
module tb_rgb565_gray_sequencer;

    localparam logic [7:0] ID = 8'd0;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  isId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    // Reference weights tracked by the bench.
    int mwr = 54;
    int mwg = 183;
    int mwb = 19;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    rgb565_gray_sequencer #(.customInstructionID(ID)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .isId   (isId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Gray value of four packed pixels from the arithmetic rules, using integers.
    function automatic logic [31:0] model(input logic [63:0] px, input int wr, input int wg,
                                          input int wb);
        logic [31:0] out;
        out = 32'd0;
        for (int k = 0; k < 4; k++) begin
            int p, r, g, b, s, y;
            p = int'(px[16*k +: 16]);
            r = (p / 2048) * 8;
            g = ((p / 32) % 64) * 4;
            b = (p % 32) * 8;
            s = r * wr + g * wg + b * wb;
            y = s / 256;
            if (y > 255) y = 255;
            out[8*k +: 8] = 8'(y);
        end
        return out;
    endfunction

    // Issue a convert; optionally inject a second convert start at cycle T+inj.
    task automatic run_convert(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int inj,
                               input logic [31:0] ia, input logic [31:0] ib);
        int first;
        int ndone;
        @(negedge clock);
        start = 1'b1; isId = ID; valueA = a; valueB = b;
        #1 chk("conv_t0_done", {31'd0, done}, 32'd0);
        @(posedge clock);
        #1 start = 1'b0; valueA = $urandom; valueB = $urandom;
        first = 0;
        ndone = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (n == inj) begin
                start = 1'b1; isId = ID; valueA = ia; valueB = ib;
            end
            if (n == inj + 1) start = 1'b0;
            #1;
            if (done) begin
                ndone++;
                if (first == 0) first = n;
            end
            chk("conv_result", result, done ? exp : 32'd0);
        end
        chk("conv_done_cycle", first, 5);
        chk("conv_done_count", ndone, 1);
    endtask

    // Issue a config; done and the old weights must appear in the same cycle.
    task automatic run_config(input logic [31:0] a);
        logic [31:0] exp_old;
        exp_old = {8'd0, 8'(mwb), 8'(mwg), 8'(mwr)};
        @(negedge clock);
        start = 1'b1; isId = ID + 8'd1; valueA = a; valueB = $urandom;
        #1 chk("cfg_done", {31'd0, done}, 32'd1);
        chk("cfg_result", result, exp_old);
        @(posedge clock);
        #1 start = 1'b0;
        mwr = int'(a[7:0]);
        mwg = int'(a[15:8]);
        mwb = int'(a[23:16]);
        #1 chk("cfg_done_drop", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, ia, ib;
        int cnt;

        vecs[0] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'hFAFAFAFA};
        vecs[1] = '{a: 32'h07E0F800, b: 32'h0000001F, exp: 32'h0012B434};
        vecs[2] = '{a: 32'h00000000, b: 32'h00000000, exp: 32'h00000000};
        vecs[3] = '{a: 32'hF800F800, b: 32'h001F07E0, exp: 32'h12B43434};

        reset = 1'b1; start = 1'b0; isId = 8'd0; valueA = 32'd0; valueB = 32'd0;
        repeat (3) @(negedge clock);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        // Fixed vectors with default weights.
        for (int i = 0; i < 4; i++) begin
            run_convert(vecs[i].a, vecs[i].b, vecs[i].exp, 0, 32'd0, 32'd0);
        end

        // Config to flat weights; white then saturates.
        run_config(32'h00808080);
        run_convert(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0, 32'd0);

        // Convert start during CONV must be ignored.
        ra = $urandom; rb = $urandom; ia = $urandom; ib = $urandom;
        run_convert(ra, rb, model({rb, ra}, mwr, mwg, mwb), 2, ia, ib);

        // Wrong-ID start: no done for 10 cycles.
        @(negedge clock);
        start = 1'b1; isId = ID + 8'd2; valueA = 32'hFFFFFFFF; valueB = 32'hFFFFFFFF;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (done) cnt++;
        end
        start = 1'b0;
        chk("wrong_id_dones", cnt, 0);

        // Reset at T+3 of a convert aborts it and restores default weights.
        @(negedge clock);
        start = 1'b1; isId = ID; valueA = 32'hFFFFFFFF; valueB = 32'hFFFFFFFF;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1 chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        mwr = 54; mwg = 183; mwb = 19;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_convert(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, 0, 32'd0, 32'd0);

        // Random converts with occasional random weight configs.
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 3) run_config($urandom);
            ra = $urandom; rb = $urandom;
            run_convert(ra, rb, model({rb, ra}, mwr, mwg, mwb), 0, 32'd0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb565_gray_sequencer.md
# rgb565_gray_sequencer

Multi-cycle custom-instruction controller that converts four RGB565 pixels to four 8-bit grayscale values per instruction. It time-shares one weighted-sum grayscale datapath across the four pixels, one per cycle. It also holds programmable channel weights, loaded by a second instruction ID. The block sits on the CPU custom-instruction bus, alongside the other custom-instruction modules.

## Interface

Parameters:
- customInstructionID, 8'd0: ID of the convert instruction. The config instruction uses ID customInstructionID+1.

Ports:
- clock, input, 1: system clock; single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: instruction-valid strobe from the CPU.
- isId, input, 8: instruction ID. Qualifies start.
- valueA, input, 32: convert: pixel1 in [31:16], pixel0 in [15:0]. Config: weights.
- valueB, input, 32: convert: pixel3 in [31:16], pixel2 in [15:0]. Ignored by config.
- done, output, 1: single-cycle completion pulse.
- result, output, 32: valid only while done=1; otherwise 32'b0.

## Operation

- Weight register: wR, wG, wB, 8 bits each.
  - Reset values are 54, 183 and 19.
  - Config instruction (start=1, isId=customInstructionID+1, FSM in IDLE): load wR=valueA[7:0], wG=valueA[15:8], wB=valueA[23:16]. Assert done in the same cycle, combinationally. result = {8'b0, old wB, old wG, old wR}.
  - A config instruction outside IDLE is ignored: no done, weights unchanged.
- Channel expansion, per pixel p:
  - R8 = {p[15:11],3'b0}
  - G8 = {p[10:5],2'b0}
  - B8 = {p[4:0],3'b0}
- Arithmetic:
  - sum = R8*wR + G8*wG + B8*wB, computed at 18 bits (maximum 3*255*255 = 195075).
  - gray = sum>>8, saturated to 8'hFF when sum>>8 > 255.
- FSM states:
  - IDLE: convert start → latch {valueB, valueA} into a 64-bit operand register, clear index, go to CONV.
  - CONV: each cycle the datapath processes operand[16*idx +: 16] and writes its gray value to byte idx of the result register. idx increments each cycle. After idx=3, go to DONE.
  - DONE: done=1 and result = result register for exactly one cycle, then go to IDLE.
- Byte packing: pixel0 → result[7:0], pixel1 → [15:8], pixel2 → [23:16], pixel3 → [31:24].
- Weights are sampled each CONV cycle. A weight change cannot occur mid-operation, because config is ignored outside IDLE.
- start with a non-matching isId: no effect in any state.
- start during CONV or DONE: ignored. The CPU stalls until done, so this is a protocol error, and the FSM must not restart.
- reset mid-operation: FSM goes to IDLE, and the operand register, result register and idx clear. No done is issued for the aborted operation. Weights return to their defaults.

## Timing

- Convert latency: start sampled in cycle T; CONV occupies T+1..T+4; done=1 in T+5 only. A new convert is accepted from T+6.
- Config latency: done in cycle T, zero cycles. A convert may start in T+1 and uses the new weights.
- Reset values:
  - done=0, result=32'b0, FSM=IDLE, idx=0.
  - Operand and result registers all zero.
  - Weights 54/183/19.
- done and result are registered-state driven in convert mode (decoded from DONE). They are combinational in config mode.
- result is forced to 32'b0 whenever done=0.

## Structure

- Shared package holds:
  - state enum {IDLE, CONV, DONE};
  - default weight constants (54, 183, 19);
  - config ID offset constant (1);
  - gray saturation constant 8'hFF.
- One natural sub-module: rgb565_gray_pixel. It is purely combinational: 16-bit pixel in, three 8-bit weights in, saturated 8-bit gray out. The sequencer instantiates it once.

## Test plan

- After reset: convert with valueA=32'hFFFFFFFF, valueB=32'hFFFFFFFF → done exactly at T+5, result=32'hFAFAFAFA. done=0 and result=0 in every other cycle.
- Per-channel packing: valueA=32'h07E0F800, valueB=32'h0000001F → result=32'h0012B434.
- Config: valueA=32'h00808080 with ID+1 → done in the same cycle, result=32'h0013B736. A following white convert saturates to result=32'hFFFFFFFF.
- Protocol misuse:
  - Convert start at T+2 during CONV → ignored; a single done at T+5 with the original result.
  - Wrong-ID start → no done for 10 cycles.
- Reset asserted at T+3 of a convert: outputs are 0 immediately and no done appears afterwards. A fresh convert after reset release completes with default weights.
